// File: rtl/sram_weight_banked.sv
// sram_weight_banked: lane-masked weight SRAM with RD_LAT read pipeline, write-first bypass, range check, post-reset auto-clear and optional per-lane parity (SRAM_PARITY_EN)
module sram_weight_banked #(
  parameter int DEPTH = 2636,
  parameter int WORDS_PER_ADDR = 72,
  parameter int BW_PER_PARAM = 8,
  parameter int RD_LAT = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int DW = WORDS_PER_ADDR * BW_PER_PARAM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      csb,
  input  logic                      wsb,
  input  logic [WORDS_PER_ADDR-1:0] wmask,
  input  logic [AW-1:0]             waddr,
  input  logic [DW-1:0]             wdata,
  input  logic [AW-1:0]             raddr,
  output logic [DW-1:0]             rdata,
  output logic                      rvalid,
  output logic                      ready,
  output logic                      addr_err,
  output logic                      parity_err
);
  localparam int W = WORDS_PER_ADDR;
  localparam int BW = BW_PER_PARAM;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] clr_addr;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] mem_word, rd_word;
  logic [DW-1:0] pd [RD_LAT];
  logic [RD_LAT-1:0] pv;
  logic [W-1:0] bypass;
  logic rd_acc, wr_acc, r_ok, w_ok;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      clr_addr <= '0;
    end else begin
      state <= state_nxt;
      clr_addr <= (state == CLEAR) ? clr_addr + 1'b1 : clr_addr;
    end
  end
  always_comb state_nxt = (state == CLEAR && clr_addr == LAST) ? READY : state;
  always_comb ready = state == READY;
  always_comb begin
    rd_acc = ready & ~csb;
    wr_acc = rd_acc & ~wsb;
    r_ok = {1'b0, raddr} < DEPTH_V;
    w_ok = {1'b0, waddr} < DEPTH_V;
    mem_word = r_ok ? mem[raddr] : '0;
    // same-address write lanes are forwarded so the read sees the new data
    bypass = (wr_acc && w_ok && waddr == raddr) ? wmask : '0;
    rd_word = mem_word;
    for (int i = 0; i < W; i++)
      if (bypass[i]) rd_word[i*BW +: BW] = wdata[i*BW +: BW];
  end
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[clr_addr] <= '0;
    else
      for (int i = 0; i < W; i++)
        if (wr_acc && w_ok && wmask[i]) mem[waddr][i*BW +: BW] <= wdata[i*BW +: BW];
  end
  // data stages only load on a valid so the last stage holds rdata between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) pd[i] <= '0;
      addr_err <= 1'b0;
    end else begin
      pv[0] <= rd_acc;
      if (rd_acc) pd[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
      addr_err <= rd_acc & (~r_ok | (~wsb & ~w_ok));
    end
  end
  assign rdata = pd[RD_LAT-1];
  assign rvalid = pv[RD_LAT-1];
`ifdef SRAM_PARITY_EN
  logic [W-1:0] par [DEPTH];
  logic [RD_LAT-1:0] pe;
  logic rd_perr;
  function automatic logic [W-1:0] lane_par(input logic [DW-1:0] d);
    logic [W-1:0] p;
    for (int i = 0; i < W; i++) p[i] = ^d[i*BW +: BW];
    return p;
  endfunction
  // forwarded lanes carry fresh data and cannot mismatch
  always_comb rd_perr = r_ok && |((lane_par(mem_word) ^ par[raddr]) & ~bypass);
  always_ff @(posedge clk) begin
    if (state == CLEAR) par[clr_addr] <= '0;
    else
      for (int i = 0; i < W; i++)
        if (wr_acc && w_ok && wmask[i]) par[waddr][i] <= ^wdata[i*BW +: BW];
  end
  always_ff @(posedge clk) begin
    if (rst) pe <= '0;
    else begin
      pe[0] <= rd_acc & rd_perr;
      for (int i = 1; i < RD_LAT; i++) pe[i] <= pe[i-1];
    end
  end
  assign parity_err = pe[RD_LAT-1];
  task automatic inject_parity_err(input logic [AW-1:0] index, input int lane);
    for (int i = 0; i < W; i++)
      if (i == lane) par[index][i] <= ~par[index][i];
  endtask
`else
  assign parity_err = 1'b0;
`endif
  task automatic load_param(input logic [AW-1:0] index, input logic [DW-1:0] data);
    mem[index] <= data;
`ifdef SRAM_PARITY_EN
    par[index] <= lane_par(data);
`endif
  endtask
endmodule

// File: tb/tb_sram_weight_banked.sv
// tb_sram_weight_banked: randomized scoreboard bench for sram_weight_banked
module tb_sram_weight_banked;
  // a non-power-of-two depth leaves addresses 12..15 encodable for range checks
  localparam int DEPTH = 12, W = 4, BW = 8, RD_LAT = 2, AW = 4, DW = 32;
  logic clk = 0, rst = 1, csb = 1, wsb = 1;
  logic [W-1:0] wmask = '0;
  logic [AW-1:0] waddr = '0, raddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic rvalid, ready, addr_err, parity_err;
  always #5 clk = ~clk;
  sram_weight_banked #(.DEPTH(DEPTH), .WORDS_PER_ADDR(W), .BW_PER_PARAM(BW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .csb(csb), .wsb(wsb), .wmask(wmask), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .ready(ready), .addr_err(addr_err),
    .parity_err(parity_err)
  );
  typedef struct {logic [DW-1:0] d; logic pe; int due;} exp_t;
  exp_t q[$];
  logic [DW-1:0] mm [16];
  logic [W-1:0] cr [16];
  int cyc = 0, ccnt = 0, passed = 0, total = 0;
  bit mready = 0, ae_exp = 0, armed = 0, rst_last = 0;
  logic [DW-1:0] hold = '0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
  endtask
  task automatic model();
    exp_t e;
    logic [W-1:0] byp;
    cyc++;
    if (rst) begin
      mready = 0; ccnt = 0; ae_exp = 0; armed = 1;
      q.delete();
      for (int a = 0; a < 16; a++) begin mm[a] = '0; cr[a] = '0; end
    end else if (!mready) begin
      ae_exp = 0;
      ccnt++;
      mready = ccnt == DEPTH;
    end else begin
      ae_exp = !csb && (int'(raddr) >= DEPTH || (!wsb && int'(waddr) >= DEPTH));
      if (!csb) begin
        e.d = '0; e.pe = 0; e.due = cyc + RD_LAT - 1;
        if (int'(raddr) < DEPTH) begin
          byp = (!wsb && waddr == raddr) ? wmask : '0;
          e.d = mm[raddr];
          for (int i = 0; i < W; i++) if (byp[i]) e.d[i*BW +: BW] = wdata[i*BW +: BW];
          e.pe = |(cr[raddr] & ~byp);
        end
        q.push_back(e);
        if (!wsb && int'(waddr) < DEPTH)
          for (int i = 0; i < W; i++)
            if (wmask[i]) begin mm[waddr][i*BW +: BW] = wdata[i*BW +: BW]; cr[waddr][i] = 0; end
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    model();
    #2;
  endtask
  task automatic acc(input bit c, input bit w, input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                     input logic [DW-1:0] wd, input logic [W-1:0] m);
    csb = c; wsb = w; waddr = wa; raddr = ra; wdata = wd; wmask = m;
    step();
  endtask
  task automatic rd(input logic [AW-1:0] ra);
    acc(0, 1, '0, ra, '0, '0);
  endtask
  task automatic idle(input int n);
    csb = 1; wsb = 1;
    repeat (n) step();
  endtask
  always @(negedge clk) begin
    if (armed) begin
      exp_t e;
      if (rst_last) hold = '0;
      chk("ready", 32'(ready), 32'(mready));
      chk("addr_err", 32'(addr_err), 32'(ae_exp));
      if (rvalid) begin
        if (q.size() == 0) chk("rvalid_unexpected", 32'(rvalid), 32'd0);
        else begin
          e = q.pop_front();
          chk("rvalid_cycle", cyc, e.due);
          chk("rdata", rdata, e.d);
          chk("parity_err", 32'(parity_err), 32'(e.pe));
          hold = e.d;
        end
      end else begin
        chk("rdata_hold", rdata, hold);
        chk("parity_idle", 32'(parity_err), 32'd0);
        if (q.size() > 0 && q[0].due <= cyc) begin
          chk("rvalid_missing", 32'(rvalid), 32'd1);
          void'(q.pop_front());
        end
      end
    end
    rst_last = rst;
  end
  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1;
    step();
    rst = 0;
    repeat (DEPTH) acc(0, 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom, 4'hF);
    for (int a = 0; a < DEPTH; a++) rd(4'(a));
    acc(0, 0, 4'd3, 4'd0, 32'h44332211, 4'b1111);
    acc(0, 0, 4'd3, 4'd0, 32'hAABBCCDD, 4'b0101);
    rd(4'd3);
    acc(0, 0, 4'd5, 4'd5, 32'h01020304, 4'b0011);
    acc(0, 0, 4'd13, 4'd2, 32'h55555555, 4'hF);
    rd(4'd14);
    acc(0, 0, 4'd15, 4'd13, 32'h12345678, 4'hF);
    idle(1);
    dut.load_param(4'd7, 32'hCAFEF00D);
    mm[7] = 32'hCAFEF00D; cr[7] = '0;
    rd(4'd7);
    repeat (400)
      acc($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 13)),
          4'($urandom_range(0, 13)), $urandom, 4'($urandom_range(0, 15)));
    for (int a = 0; a < DEPTH; a++) rd(4'(a));
    for (int a = 0; a < 6; a++) rd(4'(a));
    rst = 1;
    rd(4'd6);
    rst = 0;
    repeat (DEPTH) acc(0, 0, 4'($urandom_range(0, 11)), 4'($urandom_range(0, 15)), $urandom, 4'hF);
    for (int a = 0; a < DEPTH; a++) rd(4'(a));
`ifdef SRAM_PARITY_EN
    idle(1);
    dut.load_param(4'd2, 32'h000000FF);
    mm[2] = 32'h000000FF; cr[2] = '0;
    idle(1);
    dut.inject_parity_err(4'd2, 0);
    cr[2][0] = 1'b1;
    rd(4'd2);
    rd(4'd1);
    acc(0, 0, 4'd2, 4'd2, 32'h00000011, 4'b0001);
    rd(4'd2);
`endif
    idle(RD_LAT + 2);
    chk("drain", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
